fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the fetch stage: owns the PC, drives the instruction-memory request handshake,
//  buffers fetch data under backend back-pressure, and applies branch/exception redirects.
//  Generates the stall/kill controls consumed by the IF unit and the ID/DP stages.
//  Sits between instruction memory, the IF unit and the branch-resolution/commit logic.
// PARAMETERS
//  ADDR_LEN     32         PC / memory address width
//  INSN_LEN     32         instruction width; fetch data is 2*INSN_LEN
//  ENTRY_POINT  32'h0      PC after reset
//  MAX_WAIT     15         ack-wait cycles before fetch_err_o sets
// PORTS
//  clk_i           in   1            clock
//  reset_i         in   1            asynchronous, active-low reset
//  imem_req_o      out  1            fetch request, held until imem_ack_i
//  imem_addr_o     out  ADDR_LEN     request address, stable while imem_req_o=1
//  imem_ack_i      in   1            data valid on imem_data_i this cycle
//  imem_data_i     in   2*INSN_LEN   fetch data
//  redirect_i      in   1            redirect request (mispredict/exception)
//  redirect_pc_i   in   ADDR_LEN     redirect target
//  dp_full_i       in   1            backend cannot accept an instruction
//  pc_o            out  ADDR_LEN     PC to IF unit
//  idata_o         out  2*INSN_LEN   fetch data to IF unit
//  stall_IF_o      out  1            IF must hold (does not capture)
//  kill_IF_o/kill_ID_o/kill_DP_o  out 1 each   flush the stage
//  stall_ID_o/stall_DP_o          out 1 each   hold the stage
//  fetch_err_o     out  1            sticky ack-timeout flag
//  stall_cnt_o     out  32           saturating count of stall_IF_o=1 cycles
// BEHAVIOUR
//  Reset (reset_i=0, async): state=BOOT, pc=ENTRY_POINT, imem_req_o=0, kill_*=0, stall_IF_o=1,
//   fetch_err_o=0, stall_cnt_o=0, wait_cnt=0, data buffer=0, target=0.
//  States: BOOT, FETCH, HOLD, DRAIN, FLUSH. Evaluated top-down per cycle; redirect_i wins.
//  BOOT: stall_IF_o=1, req=0; next cycle -> FETCH.
//  FETCH: req=1, addr=pc, idata_o=imem_data_i.
//   ack & redirect_i       -> FLUSH, target<=redirect_pc_i (data dropped).
//   ~ack & redirect_i      -> DRAIN, target<=redirect_pc_i.
//   ack & ~dp_full_i       -> stall_IF_o=0, pc<=pc+4 (wrap mod 2^ADDR_LEN), stay FETCH.
//   ack & dp_full_i        -> buf<=imem_data_i, stall_IF_o=1, -> HOLD.
//   ~ack                   -> stall_IF_o=1, wait_cnt++.
//  HOLD: req=0, stall_IF_o=1, idata_o=buf. redirect_i -> FLUSH (target latched).
//   ~dp_full_i -> that cycle stall_IF_o=0 (IF captures buf), pc<=pc+4, -> FETCH.
//  DRAIN: req=1 on OLD addr (request cannot be withdrawn), stall_IF_o=1.
//   redirect_i overwrites target (newest wins). ack -> data discarded, -> FLUSH.
//  FLUSH: one cycle; req=0, kill_IF_o=kill_ID_o=kill_DP_o=1, stall_IF_o=1, pc<=target,
//   -> FETCH. redirect_i in FLUSH: pc<=redirect_pc_i instead, stays FLUSH one more cycle.
//  stall_ID_o = stall_DP_o = dp_full_i & ~(state==FLUSH) (combinational).
//  kill_* are 0 in every state except FLUSH.
//  wait_cnt: counts consecutive FETCH/DRAIN cycles with req=1 & ~ack; clears on ack;
//   saturates at MAX_WAIT; reaching MAX_WAIT sets fetch_err_o (cleared only by reset). FSM
//   unaffected.
//  stall_cnt_o: +1 each cycle stall_IF_o=1; saturates at 32'hFFFF_FFFF.
//  Zero-latency ack: ack in the first FETCH cycle is legal; back-to-back fetches give one
//   instruction per cycle with stall_IF_o=0.
//  Reset assertion mid-request: req drops immediately; memory side must tolerate.
// TESTING
//  1 Reset release, ack every cycle, dp_full_i=0 -> addr 0,4,8,12 on consecutive cycles,
//    stall_IF_o=1 only in BOOT cycle.
//  2 Ack delayed 3 cycles at pc=0x10 -> req/addr=0x10 held 4 cycles, stall_IF_o=1 for 3,
//    stall_cnt_o +=3, then pc=0x14.
//  3 Ack with dp_full_i=1 for 2 cycles, data=0xAAAA_BBBB -> req=0 in HOLD, idata_o=buf,
//    release cycle stall_IF_o=0 with idata_o=0xAAAA_BBBB, pc advances by 4.
//  4 redirect_i(0x200) while ack pending, ack 2 cycles later -> addr stays old, data
//    discarded, then one FLUSH cycle with all kills=1, next req addr=0x200.
//  5 Two redirects (0x300 then 0x400) during DRAIN -> fetch resumes at 0x400.
//  6 No ack for MAX_WAIT cycles -> fetch_err_o=1 and remains 1 after later acks until reset.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer owning the PC, the imem request handshake,
// back-pressure buffering, redirect handling and the IF/ID/DP stall/kill controls.
module fetch_ctrl #(
    parameter int                  ADDR_LEN    = 32,
    parameter int                  INSN_LEN    = 32,
    parameter logic [ADDR_LEN-1:0] ENTRY_POINT = '0,
    parameter int                  MAX_WAIT    = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  imem_req_o,
    output logic [ADDR_LEN-1:0]   imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [2*INSN_LEN-1:0] imem_data_i,
    input  logic                  redirect_i,
    input  logic [ADDR_LEN-1:0]   redirect_pc_i,
    input  logic                  dp_full_i,
    output logic [ADDR_LEN-1:0]   pc_o,
    output logic [2*INSN_LEN-1:0] idata_o,
    output logic                  stall_IF_o,
    output logic                  kill_IF_o,
    output logic                  kill_ID_o,
    output logic                  kill_DP_o,
    output logic                  stall_ID_o,
    output logic                  stall_DP_o,
    output logic                  fetch_err_o,
    output logic [31:0]           stall_cnt_o
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {BOOT, FETCH, HOLD, DRAIN, FLUSH} state_t;

    state_t                state, state_n;
    logic [ADDR_LEN-1:0]   pc, target;
    logic [2*INSN_LEN-1:0] dbuf;
    logic [WW-1:0]         wait_cnt, wait_nxt;

    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) state <= BOOT;
        else          state <= state_n;

    always_comb begin
        state_n    = state;
        stall_IF_o = 1'b1;
        unique case (state)
            BOOT:  state_n = FETCH;
            FETCH: begin
                state_n    = redirect_i ? (imem_ack_i ? FLUSH : DRAIN)
                           : (imem_ack_i & dp_full_i) ? HOLD : FETCH;
                stall_IF_o = redirect_i | ~imem_ack_i | dp_full_i;
            end
            HOLD: begin
                state_n    = redirect_i ? FLUSH : dp_full_i ? HOLD : FETCH;
                stall_IF_o = redirect_i | dp_full_i;
            end
            DRAIN:   state_n = imem_ack_i ? FLUSH : DRAIN;
            FLUSH:   state_n = redirect_i ? FLUSH : FETCH;
            default: state_n = BOOT;
        endcase
    end

    // DRAIN keeps presenting the old pc: an issued request cannot be withdrawn
    assign imem_req_o  = (state == FETCH) || (state == DRAIN);
    assign imem_addr_o = pc;
    assign pc_o        = pc;
    assign idata_o     = (state == HOLD) ? dbuf : imem_data_i;
    assign kill_IF_o   = (state == FLUSH);
    assign kill_ID_o   = (state == FLUSH);
    assign kill_DP_o   = (state == FLUSH);
    assign stall_ID_o  = dp_full_i & (state != FLUSH);
    assign stall_DP_o  = dp_full_i & (state != FLUSH);
    assign wait_nxt    = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) begin
            pc          <= ENTRY_POINT;
            target      <= '0;
            dbuf        <= '0;
            wait_cnt    <= '0;
            fetch_err_o <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (state == FLUSH) pc <= redirect_i ? redirect_pc_i : target;
            else if (!stall_IF_o) pc <= pc + ADDR_LEN'(4);
            if (redirect_i && state != BOOT) target <= redirect_pc_i;
            if (state == FETCH && imem_ack_i && !redirect_i && dp_full_i) dbuf <= imem_data_i;
            if (imem_req_o) wait_cnt <= imem_ack_i ? '0 : wait_nxt;
            if (imem_req_o && !imem_ack_i && wait_nxt == WW'(MAX_WAIT)) fetch_err_o <= 1'b1;
            if (stall_IF_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus random traffic checked each cycle
// against a flag-based behavioural model of the fetch sequencer.
module tb_fetch_ctrl;
    localparam int MAXW = 15;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [63:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        dp_full_i;
    logic [31:0] pc_o;
    logic [63:0] idata_o;
    logic        stall_IF_o, kill_IF_o, kill_ID_o, kill_DP_o, stall_ID_o, stall_DP_o;
    logic        fetch_err_o;
    logic [31:0] stall_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    bit          m_boot, m_flush, m_drain, m_hold, m_err;
    logic [31:0] m_pc, m_tgt, m_scnt;
    logic [63:0] m_buf;
    int          m_wait;

    fetch_ctrl #(.ADDR_LEN(32), .INSN_LEN(32), .ENTRY_POINT(32'h0), .MAX_WAIT(MAXW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .dp_full_i(dp_full_i), .pc_o(pc_o), .idata_o(idata_o),
        .stall_IF_o(stall_IF_o), .kill_IF_o(kill_IF_o), .kill_ID_o(kill_ID_o),
        .kill_DP_o(kill_DP_o), .stall_ID_o(stall_ID_o), .stall_DP_o(stall_DP_o),
        .fetch_err_o(fetch_err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_boot = 1; m_flush = 0; m_drain = 0; m_hold = 0; m_err = 0;
        m_pc = 32'h0; m_tgt = 32'h0; m_scnt = 32'h0; m_buf = 64'h0; m_wait = 0;
    endtask

    // one clock: drive at posedge+1, check at negedge, advance model at posedge
    task automatic step(input logic ack, input logic [63:0] d, input logic rd,
                        input logic [31:0] rpc, input logic full);
        logic ereq, estall;
        imem_ack_i = ack; imem_data_i = d; redirect_i = rd; redirect_pc_i = rpc; dp_full_i = full;
        #4;
        ereq   = !m_boot && !m_flush && !m_hold;
        estall = (m_boot || m_flush || m_drain) ? 1'b1 : m_hold ? (full || rd) : (!ack || rd || full);
        chk("req", imem_req_o, ereq);
        chk("stall_IF", stall_IF_o, estall);
        chk("kill", {kill_IF_o, kill_ID_o, kill_DP_o}, {3{m_flush}});
        chk("stall_ID_DP", {stall_ID_o, stall_DP_o}, {2{full && !m_flush}});
        chk("pc", pc_o, m_pc);
        chk("fetch_err", fetch_err_o, m_err);
        chk("stall_cnt", stall_cnt_o, m_scnt);
        if (ereq) chk("addr", imem_addr_o, m_pc);
        if (!estall) chk("idata", idata_o, m_hold ? m_buf : d);
        @(posedge clk_i);
        if (estall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        if (ereq) begin
            m_wait = ack ? 0 : (m_wait < MAXW ? m_wait + 1 : m_wait);
            if (m_wait == MAXW) m_err = 1;
        end
        if (m_boot) m_boot = 0;
        else if (m_flush) begin
            if (rd) begin m_pc = rpc; m_tgt = rpc; end
            else begin m_pc = m_tgt; m_flush = 0; end
        end else if (m_drain) begin
            if (rd) m_tgt = rpc;
            if (ack) begin m_drain = 0; m_flush = 1; end
        end else if (m_hold) begin
            if (rd) begin m_tgt = rpc; m_hold = 0; m_flush = 1; end
            else if (!full) begin m_pc = m_pc + 4; m_hold = 0; end
        end else if (rd) begin
            m_tgt = rpc;
            if (ack) m_flush = 1; else m_drain = 1;
        end else if (ack) begin
            if (full) begin m_buf = d; m_hold = 1; end
            else m_pc = m_pc + 4;
        end
        #1;
    endtask

    initial begin
        reset_i = 1'b0; imem_ack_i = 0; imem_data_i = '0; redirect_i = 0;
        redirect_pc_i = '0; dp_full_i = 0;
        mreset();
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_stall", stall_IF_o, 1'b1);
        chk("rst_kill", {kill_IF_o, kill_ID_o, kill_DP_o}, 3'b000);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_err", fetch_err_o, 1'b0);
        chk("rst_scnt", stall_cnt_o, 32'h0);
        reset_i = 1'b1;

        // back-to-back fetches with zero-latency ack
        step(1, 64'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 64'h100 + 64'(i), 0, 0, 0);
        chk("s1_pc", pc_o, 32'h10);
        chk("s1_scnt", stall_cnt_o, 32'd1);

        // ack delayed 3 cycles
        for (int i = 0; i < 3; i++) step(0, 64'h0, 0, 0, 0);
        step(1, 64'h1234, 0, 0, 0);
        chk("s2_pc", pc_o, 32'h14);
        chk("s2_scnt", stall_cnt_o, 32'd4);

        // back-pressure hold and release
        step(1, 64'hAAAA_BBBB, 0, 0, 1);
        step(0, 64'h5555, 0, 0, 1);
        step(0, 64'h6666, 0, 0, 0);
        chk("s3_pc", pc_o, 32'h18);
        chk("s3_scnt", stall_cnt_o, 32'd6);

        // redirect while ack pending
        step(0, 64'h0, 1, 32'h200, 0);
        step(0, 64'h0, 0, 0, 0);
        step(1, 64'hDEAD, 0, 0, 0);
        step(1, 64'h0, 0, 0, 0);
        chk("s4_pc", pc_o, 32'h200);

        // newest redirect during DRAIN wins
        step(0, 64'h0, 1, 32'h280, 0);
        step(0, 64'h0, 1, 32'h300, 0);
        step(0, 64'h0, 1, 32'h400, 1);
        step(1, 64'h0, 0, 0, 0);
        step(0, 64'h0, 0, 0, 0);
        chk("s5_pc", pc_o, 32'h400);

        // redirect during FLUSH, then pc wrap
        step(1, 64'h0, 1, 32'h500, 0);
        step(0, 64'h0, 1, 32'hFFFF_FFFC, 0);
        step(0, 64'h0, 0, 0, 0);
        chk("flush_redir_pc", pc_o, 32'hFFFF_FFFC);
        step(1, 64'h77, 0, 0, 0);
        chk("wrap_pc", pc_o, 32'h0);

        // ack timeout sets a sticky error
        for (int i = 0; i < MAXW; i++) step(0, 64'h0, 0, 0, 0);
        chk("s6_err", fetch_err_o, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 64'h0, 0, 0, 0);
        chk("s6_err_sticky", fetch_err_o, 1'b1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 9) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0);

        // asynchronous reset in the middle of a request
        for (int i = 0; i < 3; i++) step(1, 64'h0, 0, 0, 0);
        imem_ack_i = 0;
        #1;
        chk("mid_req_before", imem_req_o, 1'b1);
        reset_i = 1'b0;
        #1;
        chk("mid_req_drop", imem_req_o, 1'b0);
        chk("mid_stall", stall_IF_o, 1'b1);
        chk("mid_pc", pc_o, 32'h0);
        chk("mid_err", fetch_err_o, 1'b0);
        chk("mid_scnt", stall_cnt_o, 32'h0);
        mreset();
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 4) != 0, {$urandom, $urandom}, $urandom_range(0, 15) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
